// File: rtl/alu_seq_pkg.sv
// Shared types, widths and reversible-gate helpers for the ALU op sequencer.
package alu_seq_pkg;

  localparam int OPW  = 8;
  localparam int NIBW = 4;
  localparam int CNTW = 16;

  typedef enum logic [2:0] {
    OP_FA   = 3'd0,
    OP_HA   = 3'd1,
    OP_FS   = 3'd2,
    OP_HS   = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } seq_state_e;

  // Reversible gates: only the non-trivial outputs are returned.
  function automatic logic feynman(input logic ctl, input logic tgt);
    return ctl ^ tgt;
  endfunction

  function automatic logic toffoli(input logic c0, input logic c1, input logic tgt);
    return (c0 & c1) ^ tgt;
  endfunction

  function automatic logic [1:0] peres(input logic a, input logic b, input logic c);
    return {a ^ b, (a & b) ^ c};
  endfunction

  function automatic logic uses_cin(input alu_op_e op);
    return (op == OP_FA) || (op == OP_FS);
  endfunction

endpackage

// File: rtl/alu_nibble_core.sv
// Combinational 4-bit ALU slice built from reversible gates.
// Subtract runs as a + ~b + ~borrow_in, so cout carries the borrow for FS/HS.
module alu_nibble_core
  import alu_seq_pkg::*;
(
  input  logic [NIBW-1:0] a,
  input  logic [NIBW-1:0] b,
  input  logic            cin,
  input  logic [2:0]      op,
  output logic [NIBW-1:0] result,
  output logic            cout
);

  alu_op_e         op_s;
  logic            sub_s;
  logic            c_s;
  logic [1:0]      g1_s;
  logic [1:0]      g2_s;
  logic [NIBW-1:0] bx_s;
  logic [NIBW-1:0] sum_s;
  logic [NIBW-1:0] and_s;
  logic [NIBW-1:0] xor_s;
  logic [NIBW-1:0] or_s;

  // Ripple of Peres-gate full adders plus bitwise logic results, then op select.
  always_comb begin
    op_s   = alu_op_e'(op);
    sub_s  = (op_s == OP_FS) || (op_s == OP_HS);
    c_s    = feynman(sub_s, cin);
    g1_s   = 2'b00;
    g2_s   = 2'b00;
    bx_s   = {NIBW{1'b0}};
    sum_s  = {NIBW{1'b0}};
    and_s  = {NIBW{1'b0}};
    xor_s  = {NIBW{1'b0}};
    or_s   = {NIBW{1'b0}};
    result = {NIBW{1'b0}};
    cout   = 1'b0;
    for (int i = 0; i < NIBW; i++) begin
      bx_s[i]  = feynman(sub_s, b[i]);
      g1_s     = peres(a[i], bx_s[i], 1'b0);
      g2_s     = peres(g1_s[1], c_s, g1_s[0]);
      sum_s[i] = g2_s[1];
      c_s      = g2_s[0];
      and_s[i] = toffoli(a[i], b[i], 1'b0);
      xor_s[i] = feynman(a[i], b[i]);
      or_s[i]  = feynman(xor_s[i], and_s[i]);
    end
    case (op_s)
      OP_FA, OP_HA, OP_FS, OP_HS: begin
        result = sum_s;
        cout   = feynman(sub_s, c_s);
      end
      OP_AND:  result = and_s;
      OP_OR:   result = or_s;
      OP_XOR:  result = xor_s;
      OP_XNOR: result = ~xor_s;
      default: begin
        result = {NIBW{1'b0}};
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs 8-bit ALU ops as two passes (low then high nibble) through one nibble core.
// Optional completed-operation counter enabled by macro ALU_SEQ_PERF_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [OPW-1:0]  req_a,
  input  logic [OPW-1:0]  req_b,
  input  logic            req_cin,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [OPW-1:0]  rsp_result,
  output logic            rsp_flag,
  output logic [CNTW-1:0] perf_count
);

  seq_state_e      state_r;
  seq_state_e      state_s;
  alu_op_e         op_r;
  logic [OPW-1:0]  a_r;
  logic [OPW-1:0]  b_r;
  logic            carry_r;
  logic [NIBW-1:0] lo_r;
  logic            rsp_valid_r;
  logic [OPW-1:0]  rsp_result_r;
  logic            rsp_flag_r;
  logic [NIBW-1:0] nib_a_s;
  logic [NIBW-1:0] nib_b_s;
  logic [NIBW-1:0] nib_res_s;
  logic            nib_cout_s;

  assign req_ready  = (state_r == ST_IDLE);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flag   = rsp_flag_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = ST_LO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LO:   state_s = ST_HI;
      ST_HI:   state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand nibble select for the shared core.
  always_comb begin
    if (state_r == ST_HI) begin
      nib_a_s = a_r[OPW-1:NIBW];
      nib_b_s = b_r[OPW-1:NIBW];
    end else begin
      nib_a_s = a_r[NIBW-1:0];
      nib_b_s = b_r[NIBW-1:0];
    end
  end

  alu_nibble_core u_core (
    .a      (nib_a_s),
    .b      (nib_b_s),
    .cin    (carry_r),
    .op     (op_r),
    .result (nib_res_s),
    .cout   (nib_cout_s)
  );

  // State, captured request, inter-pass carry and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_FA;
      a_r          <= {OPW{1'b0}};
      b_r          <= {OPW{1'b0}};
      carry_r      <= 1'b0;
      lo_r         <= {NIBW{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {OPW{1'b0}};
      rsp_flag_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r    <= alu_op_e'(req_op);
            a_r     <= req_a;
            b_r     <= req_b;
            carry_r <= uses_cin(alu_op_e'(req_op)) ? req_cin : 1'b0;
          end
        end
        ST_LO: begin
          lo_r    <= nib_res_s;
          carry_r <= nib_cout_s;
        end
        ST_HI: begin
          rsp_result_r <= {nib_res_s, lo_r};
          rsp_flag_r   <= nib_cout_s;
          rsp_valid_r  <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [CNTW-1:0] perf_r;

  // Saturating count of response handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_r <= {CNTW{1'b0}};
    end else if (rsp_valid_r && rsp_ready && (perf_r != {CNTW{1'b1}})) begin
      perf_r <= perf_r + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign perf_count = perf_r;
`else
  assign perf_count = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed vector table, reset-in-flight sequence, random ops vs model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_flag;
  logic [15:0] perf_count;

  int passes = 0;
  int total  = 0;
  int perf_m = 0;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .perf_count (perf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       flag;
    int         bp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef ALU_SEQ_PERF_EN
    return (perf_m > 65535) ? 32'd65535 : 32'(perf_m);
`else
    return 32'd0;
`endif
  endfunction

  // Reference: whole-word arithmetic straight from the operation definitions.
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    int ai, bi, ci, r;
    ai = int'(a);
    bi = int'(b);
    ci = (op == 3'd0 || op == 3'd2) ? int'(cin) : 0;
    case (op)
      3'd0, 3'd1: begin
        r = ai + bi + ci;
        return {r[8], r[7:0]};
      end
      3'd2, 3'd3: begin
        r = (ai - bi - ci + 256) % 256;
        return {(ai < bi + ci), r[7:0]};
      end
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a ^ b};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] er, input logic ef, input int bp);
    int n;
    logic [31:0] rnd;
    logic [7:0] held_r;
    logic held_f;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    rsp_ready = (bp == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rnd = $urandom;
    req_op  = rnd[2:0];
    req_a   = rnd[15:8];
    req_b   = rnd[23:16];
    req_cin = rnd[24];
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'd2);
    check("result", 32'(rsp_result), 32'(er));
    check("flag", 32'(rsp_flag), 32'(ef));
    held_r = rsp_result;
    held_f = rsp_flag;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_result", 32'(rsp_result), 32'(held_r));
      check("bp_flag", 32'(rsp_flag), 32'(held_f));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    perf_m++;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_idle", 32'(req_ready), 32'd1);
    check("perf", 32'(perf_count), exp_perf());
  endtask

  vec_t vecs[7];
  logic [8:0] m;
  logic [31:0] r;

  initial begin
    vecs[0] = '{3'd0, 8'hF0, 8'h1F, 1'b1, 8'h10, 1'b1, 0};
    vecs[1] = '{3'd3, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0};
    vecs[2] = '{3'd3, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0};
    vecs[3] = '{3'd2, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 0};
    vecs[4] = '{3'd4, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b0, 0};
    vecs[5] = '{3'd7, 8'hA5, 8'h0F, 1'b0, 8'h55, 1'b0, 0};
    vecs[6] = '{3'd1, 8'hC3, 8'h7E, 1'b1, 8'h41, 1'b1, 5};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_a = 8'h00;
    req_b = 8'h00;
    req_cin = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flag", 32'(rsp_flag), 32'd0);
    check("rst_perf", 32'(perf_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].flag, vecs[i].bp);
    end

    // Reset while the operation sits in the high-nibble pass.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 8'h33;
    req_b = 8'h44;
    req_cin = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hi_busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    perf_m = 0;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_result", 32'(rsp_result), 32'd0);
    check("abort_flag", 32'(rsp_flag), 32'd0);
    check("abort_perf", 32'(perf_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      r = $urandom;
      m = ref_op(r[2:0], r[15:8], r[23:16], r[24]);
      run_op(r[2:0], r[15:8], r[23:16], r[24], m[7:0], m[8], int'(r[27:26]) % 3);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
